// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: state encodings and select-width helper shared by the mux_pipe slice
package mux_pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;
  function automatic int sel_w_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_sel.sv
// mux_sel: combinational N:1 line selector, zero data plus err flag when sel >= N
module mux_sel #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] lines,
  output logic [WIDTH-1:0]   data,
  output logic               err
);
  logic [WIDTH-1:0] tbl [2**SEL_W];
  // Unused codes are padded with zero so an out-of-range select reads 0, never X/z.
  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_tbl
    if (i < N) begin : g_line
      assign tbl[i] = lines[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign tbl[i] = '0;
    end
  end
  assign data = tbl[sel];
  assign err  = 32'(sel) >= N;
endmodule

// File: rtl/mux_pipe.sv
// mux_pipe: N:1 selector with registered valid/ready output and a 2-entry skid buffer
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] lines,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err
);
  if (N < 2 || N > 64 || SEL_W < sel_w_for(N)) begin : g_param_chk
    $error("mux_pipe: N must be 2..64 and 2**SEL_W >= N");
  end
  state_t           state, nxt;
  logic [WIDTH-1:0] new_data, skid_data;
  logic             new_err, skid_err;
  logic             acc, pop, ld_main, ld_skid;
  mux_sel #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) u_sel (
    .sel  (sel),
    .lines(lines),
    .data (new_data),
    .err  (new_err)
  );
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_comb begin
    nxt     = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        nxt     = acc ? ST_ONE : ST_EMPTY;
        ld_main = acc;
      end
      ST_ONE: begin
        nxt     = (acc && !pop) ? ST_TWO : ((!acc && pop) ? ST_EMPTY : ST_ONE);
        ld_main = acc && pop;
        ld_skid = acc && !pop;
      end
      ST_TWO: begin
        nxt     = pop ? ST_ONE : ST_TWO;
        ld_main = pop;
      end
      default: nxt = ST_EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= nxt;
  end
  // Handshake flags are registered from the next state so no output is a combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      out_valid <= nxt != ST_EMPTY;
      in_ready  <= nxt != ST_TWO;
      if (ld_main) begin
        out_data <= (state == ST_TWO) ? skid_data : new_data;
        out_err  <= (state == ST_TWO) ? skid_err : new_err;
      end
      if (ld_skid) begin
        skid_data <= new_data;
        skid_err  <= new_err;
      end
    end
  end
endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: directed checks of mux_pipe (N=8 instance a, N=6 instance b)
module tb_mux_pipe;
  logic          clk = 1'b0;
  logic          rst;
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [2:0]    a_sel;
  logic [255:0]  a_lines;
  logic [31:0]   a_out_data;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [2:0]    b_sel;
  logic [191:0]  b_lines;
  logic [31:0]   b_out_data;
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  mux_pipe #(.WIDTH(32), .N(8), .SEL_W(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .sel(a_sel),
    .lines(a_lines), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_err(a_out_err)
  );

  mux_pipe #(.WIDTH(32), .N(6), .SEL_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .sel(b_sel),
    .lines(b_lines), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_err(b_out_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_in_valid = 1'b1; a_sel = 3'd3; a_out_ready = 1'b0;
    step(); step();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    n_checks++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 00000000", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
    n_checks++; if (a_out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %b exp 0", a_out_err); end
    rst = 1'b0; a_in_valid = 1'b0;
    step();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ignored_input got %b exp 0", a_out_valid); end
  endtask

  task automatic test_basic();
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_sel = 3'd5;
    step();
    a_in_valid = 1'b0;
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", a_out_valid); end
    n_checks++; if (a_out_data !== 32'hA000_0005) begin n_fail++; $display("FAIL basic_data got %h exp a0000005", a_out_data); end
    n_checks++; if (a_out_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b exp 0", a_out_err); end
    step();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b exp 0", a_out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1; a_sel = 3'(i);
      step();
      exp = 32'hA000_0000 + 32'(i);
      n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp) begin n_fail++; $display("FAIL stream_%0d got v=%b %h exp v=1 %h", i, a_out_valid, a_out_data, exp); end
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_%0d got %b exp 1", i, a_in_ready); end
    end
    a_in_valid = 1'b0;
    step();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b exp 0", a_out_valid); end
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 3'd1;
    step();
    n_checks++; if (a_in_ready !== 1'b1 || a_out_data !== 32'hA000_0001) begin n_fail++; $display("FAIL bp_one got rdy=%b %h exp rdy=1 a0000001", a_in_ready, a_out_data); end
    a_sel = 3'd2;
    step();
    a_in_valid = 1'b0;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_two_ready got %b exp 0", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hA000_0001) begin n_fail++; $display("FAIL bp_two_data got v=%b %h exp v=1 a0000001", a_out_valid, a_out_data); end
    step();
    n_checks++; if (a_in_ready !== 1'b0 || a_out_data !== 32'hA000_0001) begin n_fail++; $display("FAIL bp_hold got rdy=%b %h exp rdy=0 a0000001", a_in_ready, a_out_data); end
    a_out_ready = 1'b1;
    step();
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hA000_0002) begin n_fail++; $display("FAIL bp_second got v=%b %h exp v=1 a0000002", a_out_valid, a_out_data); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b exp 1", a_in_ready); end
    step();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b exp 0", a_out_valid); end
  endtask

  task automatic test_out_of_range();
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_sel = 3'd7;
    step();
    n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h0 || b_out_err !== 1'b1) begin n_fail++; $display("FAIL oor_7 got v=%b %h e=%b exp v=1 00000000 e=1", b_out_valid, b_out_data, b_out_err); end
    b_sel = 3'd2;
    step();
    n_checks++; if (b_out_data !== 32'hB000_0002 || b_out_err !== 1'b0) begin n_fail++; $display("FAIL oor_next got %h e=%b exp b0000002 e=0", b_out_data, b_out_err); end
    b_sel = 3'd6;
    step();
    n_checks++; if (b_out_data !== 32'h0 || b_out_err !== 1'b1) begin n_fail++; $display("FAIL oor_eq_n got %h e=%b exp 00000000 e=1", b_out_data, b_out_err); end
    b_sel = 3'd5;
    step();
    b_in_valid = 1'b0;
    n_checks++; if (b_out_data !== 32'hB000_0005 || b_out_err !== 1'b0) begin n_fail++; $display("FAIL oor_last got %h e=%b exp b0000005 e=0", b_out_data, b_out_err); end
    step();
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL oor_drain got %b exp 0", b_out_valid); end
  endtask

  task automatic test_mid_reset();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 3'd3;
    step();
    a_sel = 3'd4;
    step();
    a_in_valid = 1'b0;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_two got %b exp 0", a_in_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0; a_out_ready = 1'b1;
    n_checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_reset got v=%b %h rdy=%b exp v=0 00000000 rdy=1", a_out_valid, a_out_data, a_in_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_no_ghost_%0d got %b exp 0", i, a_out_valid); end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) a_lines[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    for (int k = 0; k < 6; k++) b_lines[k*32 +: 32] = 32'hB000_0000 + 32'(k);
    rst = 1'b1;
    a_in_valid = 1'b0; a_sel = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_sel = '0; b_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_out_of_range();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
